// File: rtl/resource_agu_pkg.sv
// Shared types and instruction-field layout for the resource-port address generator.
package resource_agu_pkg;

    localparam int FIELD_W = 12;
    localparam int HALF_W  = 6;

    localparam logic [2:0] OPCODE_REP  = 3'd0;
    localparam logic [2:0] OPCODE_REPX = 3'd1;

    // instr_body layout: slot[27:24] port[23:22] level[21:18] iter[17:12] step[11:6] delay[5:0]
    localparam int SLOT_LSB  = 24;
    localparam int PORT_LSB  = 22;
    localparam int LEVEL_LSB = 18;
    localparam int ITER_LSB  = 12;
    localparam int STEP_LSB  = 6;
    localparam int DELAY_LSB = 0;

    typedef struct packed {
        logic [FIELD_W-1:0] iter;
        logic [FIELD_W-1:0] step;
        logic [FIELD_W-1:0] delay;
    } agu_level_cfg_t;

    // rep fills the low half of each field, repx the high half; the other half is kept.
    function automatic agu_level_cfg_t cfg_merge(
        input agu_level_cfg_t    cur,
        input logic              upper,
        input logic [HALF_W-1:0] it,
        input logic [HALF_W-1:0] st,
        input logic [HALF_W-1:0] dl
    );
        agu_level_cfg_t r;
        r = cur;
        if (upper) begin
            r.iter[FIELD_W-1:HALF_W]  = it;
            r.step[FIELD_W-1:HALF_W]  = st;
            r.delay[FIELD_W-1:HALF_W] = dl;
        end else begin
            r.iter[HALF_W-1:0]  = it;
            r.step[HALF_W-1:0]  = st;
            r.delay[HALF_W-1:0] = dl;
        end
        return r;
    endfunction

endpackage

// File: rtl/resource_agu_level_counter.sv
// One loop level: index counter plus the idx*step offset it has contributed, used to rewind on wrap.
module resource_agu_level_counter
    import resource_agu_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance_i,
    input  logic                  carry_i,
    input  agu_level_cfg_t        cfg_i,
    output logic                  carry_o,
    output logic                  inc_o,
    output logic                  wrap_o,
    output logic [ADDR_WIDTH-1:0] step_o,
    output logic [ADDR_WIDTH-1:0] offset_o
);

    logic [FIELD_W-1:0]    idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] offset_q, offset_d;
    logic                  at_max;

    assign at_max   = (idx_q == cfg_i.iter);
    assign carry_o  = carry_i & at_max;
    assign inc_o    = advance_i & carry_i & ~at_max;
    assign wrap_o   = advance_i & carry_i & at_max;
    assign step_o   = ADDR_WIDTH'($signed(cfg_i.step));
    assign offset_o = offset_q;

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        idx_d    = idx_q;
        offset_d = offset_q;
        if (inc_o) begin
            idx_d    = idx_q + 1'b1;
            offset_d = offset_q + step_o;
        end else if (wrap_o) begin
            idx_d    = '0;
            offset_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            offset_q <= '0;
        end else begin
            idx_q    <= idx_d;
            offset_q <= offset_d;
        end
    end

endmodule

// File: rtl/resource_rep_agu.sv
// Multi-level nested-loop address generator for one resource port, configured by rep/repx.
module resource_rep_agu
    import resource_agu_pkg::*;
#(
    parameter int NUM_LEVELS  = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int FIELD_WIDTH = FIELD_W,
    parameter int PORT_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [2:0]            instr_opcode,
    input  logic [27:0]           instr_body,
    input  logic                  activate,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  instr_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [FIELD_WIDTH-1:0] delay_q, delay_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    agu_level_cfg_t         cfg_q [NUM_LEVELS];
    agu_level_cfg_t         cfg_d [NUM_LEVELS];

    logic [1:0]        instr_port;
    logic [3:0]        instr_level;
    logic [HALF_W-1:0] f_iter, f_step, f_delay;
    logic              unused_slot;
    logic              is_cfg, level_ok, cfg_wr;

    assign instr_port  = instr_body[PORT_LSB +: 2];
    assign instr_level = instr_body[LEVEL_LSB +: 4];
    assign f_iter      = instr_body[ITER_LSB +: HALF_W];
    assign f_step      = instr_body[STEP_LSB +: HALF_W];
    assign f_delay     = instr_body[DELAY_LSB +: HALF_W];
    assign unused_slot = ^instr_body[SLOT_LSB +: 4];

    assign is_cfg   = instr_valid && (instr_opcode == OPCODE_REP || instr_opcode == OPCODE_REPX)
                      && (instr_port == 2'(PORT_ID));
    assign level_ok = 32'(instr_level) < NUM_LEVELS;
    assign cfg_wr   = is_cfg && level_ok && (state_q == ST_IDLE);
    assign err_d    = is_cfg && !cfg_wr;

    logic                  advance, last;
    logic [NUM_LEVELS:0]   carry;
    logic [NUM_LEVELS-1:0] lvl_inc, lvl_wrap;
    logic [ADDR_WIDTH-1:0] lvl_step   [NUM_LEVELS];
    logic [ADDR_WIDTH-1:0] lvl_offset [NUM_LEVELS];

    assign advance  = (state_q == ST_RUN) && addr_ready;
    assign carry[0] = 1'b1;
    assign last     = carry[NUM_LEVELS];

    // Level 0 always sees a carry; the lowest level not at its limit increments, those below wrap.
    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_level
        resource_agu_level_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .advance_i(advance),
            .carry_i  (carry[g]),
            .cfg_i    (cfg_q[g]),
            .carry_o  (carry[g+1]),
            .inc_o    (lvl_inc[g]),
            .wrap_o   (lvl_wrap[g]),
            .step_o   (lvl_step[g]),
            .offset_o (lvl_offset[g])
        );
    end

    logic [ADDR_WIDTH-1:0]  step_sum, rewind_sum, next_addr;
    logic [FIELD_WIDTH-1:0] next_delay;

    always_comb begin
        step_sum   = '0;
        rewind_sum = '0;
        next_delay = '0;
        for (int l = 0; l < NUM_LEVELS; l++) begin
            if (lvl_inc[l]) begin
                step_sum   = lvl_step[l];
                next_delay = FIELD_WIDTH'(cfg_q[l].delay);
            end
            if (lvl_wrap[l]) rewind_sum = rewind_sum + lvl_offset[l];
        end
        next_addr = addr_q + step_sum - rewind_sum;
    end

    always_comb begin
        for (int l = 0; l < NUM_LEVELS; l++) begin
            cfg_d[l] = cfg_q[l];
            if (cfg_wr && 32'(instr_level) == l)
                cfg_d[l] = cfg_merge(cfg_q[l], instr_opcode == OPCODE_REPX, f_iter, f_step, f_delay);
            if (advance && last) cfg_d[l] = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        delay_d = delay_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (activate) begin
                state_d = ST_RUN;
                addr_d  = start_addr;
            end
            ST_RUN: if (advance) begin
                if (last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    addr_d = next_addr;
                    if (next_delay != '0) begin
                        state_d = ST_WAIT;
                        delay_d = next_delay;
                    end
                end
            end
            ST_WAIT: begin
                if (delay_q == FIELD_WIDTH'(1)) state_d = ST_RUN;
                else                            delay_d = delay_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the config array is a handful of flops that must read as zero after reset, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            delay_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cfg_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            delay_q <= delay_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cfg_q   <= cfg_d;
        end
    end

    assign addr       = addr_q;
    assign addr_valid = (state_q == ST_RUN);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign instr_err  = err_q;

endmodule

// File: tb/tb_resource_rep_agu.sv
// Directed bench for resource_rep_agu: streams, delays, wrap, stall, rejects and mid-stream reset.
module tb_resource_rep_agu;
    import resource_agu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [2:0]  instr_opcode = 3'd0;
    logic [27:0] instr_body = '0;
    logic        activate = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] addr;
    logic        addr_valid;
    logic        addr_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        instr_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] got_addr[$];
    int          got_cyc[$];
    logic [15:0] stall_addr[$];
    logic [15:0] exp_addr[$];
    int          exp_cyc[$];
    int          done_cyc;
    logic        done_seen;
    logic        e;

    resource_rep_agu #(.NUM_LEVELS(4), .ADDR_WIDTH(16), .FIELD_WIDTH(12), .PORT_ID(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_opcode(instr_opcode),
        .instr_body  (instr_body),
        .activate    (activate),
        .start_addr  (start_addr),
        .addr        (addr),
        .addr_valid  (addr_valid),
        .addr_ready  (addr_ready),
        .busy        (busy),
        .done        (done),
        .instr_err   (instr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_instr(input logic [2:0] op, input logic [1:0] port, input logic [3:0] lvl,
                              input logic [5:0] it, input logic [5:0] st, input logic [5:0] dl,
                              output logic err_seen);
        @(negedge clk);
        instr_valid  = 1'b1;
        instr_opcode = op;
        instr_body   = {4'h0, port, lvl, it, st, dl};
        @(negedge clk);
        instr_valid  = 1'b0;
        err_seen     = instr_err;
    endtask

    // Caller is at the negedge of cycle first_cyc; ready is dropped for cycles in the stall window.
    task automatic collect(input int first_cyc, input int budget, input int stall_from, input int stall_len);
        int c;
        c         = first_cyc;
        done_seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            addr_ready = !(c >= stall_from && c < stall_from + stall_len);
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = c;
                break;
            end
            if (addr_valid && addr_ready) begin
                got_addr.push_back(addr);
                got_cyc.push_back(c);
            end
            if (addr_valid && !addr_ready) stall_addr.push_back(addr);
            @(negedge clk);
            c++;
        end
        addr_ready = 1'b1;
        check("done_seen", done_seen, 1);
    endtask

    task automatic clear_got();
        got_addr.delete();
        got_cyc.delete();
        stall_addr.delete();
        done_cyc = -1;
    endtask

    task automatic run_stream(input logic [15:0] start, input int budget, input int stall_from, input int stall_len);
        clear_got();
        @(negedge clk);
        activate   = 1'b1;
        start_addr = start;
        @(negedge clk);
        activate   = 1'b0;
        collect(1, budget, stall_from, stall_len);
    endtask

    task automatic compare_stream(input string tag, input int exp_done);
        int n;
        check({tag, "_count"}, got_addr.size(), exp_addr.size());
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s_cyc%0d", tag, i), got_cyc[i], exp_cyc[i]);
        end
        check({tag, "_done_cyc"}, done_cyc, exp_done);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_addr", addr, 0);
        check("rst_valid", addr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", instr_err, 0);
        rst = 1'b0;

        // Zero config: single address at start_addr
        run_stream(16'h0010, 20, 0, 0);
        exp_addr = '{16'h0010};
        exp_cyc  = '{1};
        compare_stream("zero_cfg", 2);

        // L0 iter 3 step 2, back-to-back
        send_instr(OPCODE_REP, 2'd0, 4'd0, 6'd3, 6'd2, 6'd0, e);
        check("l0_wr_err", e, 0);
        run_stream(16'h0000, 20, 0, 0);
        exp_addr = '{16'h0, 16'h2, 16'h4, 16'h6};
        exp_cyc  = '{1, 2, 3, 4};
        compare_stream("l0_step2", 5);

        // Two levels with delays
        send_instr(OPCODE_REP, 2'd0, 4'd0, 6'd1, 6'd1, 6'd2, e);
        send_instr(OPCODE_REP, 2'd0, 4'd1, 6'd1, 6'd8, 6'd3, e);
        run_stream(16'h0000, 40, 0, 0);
        exp_addr = '{16'h0, 16'h1, 16'h8, 16'h9};
        exp_cyc  = '{1, 4, 8, 11};
        compare_stream("two_lvl_delay", 12);

        // repx upper half: iter = 64 -> 65 addresses
        send_instr(OPCODE_REP,  2'd0, 4'd0, 6'd0, 6'd1, 6'd0, e);
        send_instr(OPCODE_REPX, 2'd0, 4'd0, 6'd1, 6'd0, 6'd0, e);
        run_stream(16'h0000, 100, 0, 0);
        exp_addr.delete();
        exp_cyc.delete();
        for (int i = 0; i <= 64; i++) begin
            exp_addr.push_back(16'(i));
            exp_cyc.push_back(i + 1);
        end
        compare_stream("repx_iter64", 66);

        // Negative step with wrap below zero
        send_instr(OPCODE_REP,  2'd0, 4'd0, 6'd2, 6'h3F, 6'd0, e);
        send_instr(OPCODE_REPX, 2'd0, 4'd0, 6'd0, 6'h3F, 6'd0, e);
        run_stream(16'h0001, 20, 0, 0);
        exp_addr = '{16'h0001, 16'h0000, 16'hFFFF};
        exp_cyc  = '{1, 2, 3};
        compare_stream("neg_step", 4);

        // Stall: ready low for cycles 2..4
        send_instr(OPCODE_REP, 2'd0, 4'd0, 6'd3, 6'd2, 6'd0, e);
        run_stream(16'h0000, 30, 2, 3);
        exp_addr = '{16'h0, 16'h2, 16'h4, 16'h6};
        exp_cyc  = '{1, 5, 6, 7};
        compare_stream("stall", 8);
        check("stall_len", stall_addr.size(), 3);
        foreach (stall_addr[i]) check($sformatf("stall_hold%0d", i), stall_addr[i], 16'h2);

        // Rejected and ignored instructions leave config unchanged
        send_instr(OPCODE_REP, 2'd0, 4'd0, 6'd1, 6'd5, 6'd0, e);
        check("good_wr_err", e, 0);
        send_instr(OPCODE_REP, 2'd0, 4'd7, 6'd3, 6'd9, 6'd0, e);
        check("bad_level_err", e, 1);
        @(negedge clk);
        check("err_one_cycle", instr_err, 0);
        send_instr(OPCODE_REP, 2'd1, 4'd0, 6'd3, 6'd9, 6'd0, e);
        check("other_port_err", e, 0);
        send_instr(3'd2, 2'd0, 4'd0, 6'd3, 6'd9, 6'd0, e);
        check("other_op_err", e, 0);
        run_stream(16'h0000, 20, 0, 0);
        exp_addr = '{16'h0, 16'h5};
        exp_cyc  = '{1, 2};
        compare_stream("cfg_kept", 3);

        // Write and activate while busy: error, stream unaffected
        send_instr(OPCODE_REP, 2'd0, 4'd0, 6'd3, 6'd1, 6'd0, e);
        clear_got();
        @(negedge clk);
        activate   = 1'b1;
        start_addr = 16'h0100;
        @(negedge clk);
        if (addr_valid) begin got_addr.push_back(addr); got_cyc.push_back(1); end
        instr_valid  = 1'b1;
        instr_opcode = OPCODE_REP;
        instr_body   = {4'h0, 2'd0, 4'd0, 6'd0, 6'd7, 6'd0};
        activate     = 1'b1;
        start_addr   = 16'h0200;
        @(negedge clk);
        instr_valid = 1'b0;
        activate    = 1'b0;
        check("busy_wr_err", instr_err, 1);
        if (addr_valid) begin got_addr.push_back(addr); got_cyc.push_back(2); end
        @(negedge clk);
        collect(3, 20, 0, 0);
        exp_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
        exp_cyc  = '{1, 2, 3, 4};
        compare_stream("busy_wr", 5);

        // Config write in the same cycle as activate is used by the stream
        clear_got();
        @(negedge clk);
        instr_valid  = 1'b1;
        instr_opcode = OPCODE_REP;
        instr_body   = {4'h0, 2'd0, 4'd0, 6'd1, 6'd3, 6'd0};
        activate     = 1'b1;
        start_addr   = 16'h0000;
        @(negedge clk);
        instr_valid = 1'b0;
        activate    = 1'b0;
        check("same_cyc_err", instr_err, 0);
        collect(1, 20, 0, 0);
        exp_addr = '{16'h0, 16'h3};
        exp_cyc  = '{1, 2};
        compare_stream("same_cyc_wr", 3);

        // Reset mid-stream
        send_instr(OPCODE_REP, 2'd0, 4'd0, 6'd7, 6'd1, 6'd0, e);
        @(negedge clk);
        activate   = 1'b1;
        start_addr = 16'h0000;
        @(negedge clk);
        activate = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", addr_valid, 0);
        check("mid_rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", done, 0);
        run_stream(16'h0020, 20, 0, 0);
        exp_addr = '{16'h0020};
        exp_cyc  = '{1};
        compare_stream("post_rst_cfg", 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
